// File: rtl/byte_line_reader.sv
// Line-oriented byte stream reader: assembles stream bytes into newline/full/EOF
// terminated lines, with a one-byte pushback slot, position tracking and rewind.
module byte_line_reader #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned POS_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic                 unget_valid,
  input  logic [7:0]           unget_data,
  output logic                 unget_ready,
  input  logic                 rewind,
  output logic                 line_valid,
  input  logic                 line_ready,
  output logic [8*MAX_LEN-1:0] line_data,
  output logic [LEN_W-1:0]     line_len,
  output logic                 line_trunc,
  output logic                 line_eof,
  output logic                 eof,
  output logic                 err,
  output logic [POS_W-1:0]     pos
);

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    EMIT     = 2'd1,
    EOF_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       buf_q [MAX_LEN];
  logic [7:0]       buf_d [MAX_LEN];
  logic [LEN_W-1:0] len_q, len_d;
  logic             pb_full_q, pb_full_d;
  logic [7:0]       pb_data_q, pb_data_d;
  logic             line_valid_q, line_valid_d;
  logic             line_trunc_q, line_trunc_d;
  logic             line_eof_q, line_eof_d;
  logic             err_q, err_d;
  logic [POS_W-1:0] pos_q, pos_d;

  logic             take_pb, take_st, consume, unget_acc;
  logic [7:0]       byte_in;
  logic [LEN_W-1:0] len_inc;
  logic [POS_W-1:0] pos_inc;

  assign in_ready    = (state_q == COLLECT) && !pb_full_q;
  assign unget_ready = !pb_full_q && (state_q != EOF_DONE);
  assign eof         = (state_q == EOF_DONE);
  assign err         = err_q;
  assign pos         = pos_q;
  assign line_valid  = line_valid_q;
  assign line_trunc  = line_trunc_q;
  assign line_eof    = line_eof_q;
  assign line_len    = line_valid_q ? len_q : '0;

  always_comb begin
    line_data = '0;
    for (int unsigned k = 0; k < MAX_LEN; k++) begin
      line_data[8*k +: 8] = line_valid_q ? buf_q[k] : 8'h00;
    end
  end

  // Pushback wins over the stream: in_ready is already low whenever it is full.
  assign take_pb   = (state_q == COLLECT) && pb_full_q;
  assign take_st   = in_valid && in_ready;
  assign consume   = take_pb || take_st;
  assign byte_in   = take_pb ? pb_data_q : in_data;
  assign unget_acc = unget_valid && unget_ready;
  assign len_inc   = len_q + 1'b1;
  assign pos_inc   = pos_q + {{(POS_W-1){1'b0}}, consume};

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    len_d        = len_q;
    pb_full_d    = pb_full_q;
    pb_data_d    = pb_data_q;
    line_valid_d = line_valid_q;
    line_trunc_d = line_trunc_q;
    line_eof_d   = line_eof_q;
    err_d        = err_q;
    pos_d        = pos_q;

    if (rewind) begin
      state_d      = COLLECT;
      buf_d        = '{default: 8'h00};
      len_d        = '0;
      pb_full_d    = 1'b0;
      pb_data_d    = '0;
      line_valid_d = 1'b0;
      line_trunc_d = 1'b0;
      line_eof_d   = 1'b0;
      err_d        = 1'b0;
      pos_d        = '0;
    end else begin
      if (unget_valid && !unget_ready) err_d = 1'b1;
      if (take_pb) pb_full_d = 1'b0;
      // A same-cycle stream byte counts first, so the saturating decrement applies after it.
      pos_d = pos_inc;
      if (unget_acc) begin
        pb_full_d = 1'b1;
        pb_data_d = unget_data;
        if (pos_inc != '0) pos_d = pos_inc - 1'b1;
      end

      case (state_q)
        COLLECT: begin
          if (consume) begin
            for (int unsigned k = 0; k < MAX_LEN; k++) begin
              if (len_q == LEN_W'(k)) buf_d[k] = byte_in;
            end
            len_d = len_inc;
            if ((take_st && in_last) || (byte_in == 8'h0A) || (len_inc == LEN_W'(MAX_LEN))) begin
              state_d      = EMIT;
              line_valid_d = 1'b1;
              line_eof_d   = take_st && in_last;
              line_trunc_d = (len_inc == LEN_W'(MAX_LEN)) && (byte_in != 8'h0A);
            end
          end
        end
        EMIT: begin
          if (line_ready) begin
            buf_d        = '{default: 8'h00};
            len_d        = '0;
            line_valid_d = 1'b0;
            line_trunc_d = 1'b0;
            line_eof_d   = 1'b0;
            state_d      = line_eof_q ? EOF_DONE : COLLECT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= COLLECT;
      buf_q        <= '{default: 8'h00};
      len_q        <= '0;
      pb_full_q    <= 1'b0;
      pb_data_q    <= '0;
      line_valid_q <= 1'b0;
      line_trunc_q <= 1'b0;
      line_eof_q   <= 1'b0;
      err_q        <= 1'b0;
      pos_q        <= '0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      len_q        <= len_d;
      pb_full_q    <= pb_full_d;
      pb_data_q    <= pb_data_d;
      line_valid_q <= line_valid_d;
      line_trunc_q <= line_trunc_d;
      line_eof_q   <= line_eof_d;
      err_q        <= err_d;
      pos_q        <= pos_d;
    end
  end

endmodule
